// File: rtl/playout_scheduler.sv
// -----------------------------------------------------------------------------
// playout_scheduler
//   Drains the receive-side sample FIFO toward the retransmit path. Each
//   frame request is answered with exactly one sample (FIFO byte or
//   silence) three cycles after acceptance. It waits for a prefill level
//   before playing. Repeated starvation sends it back to prefill.
//
// Ports
//   clk, rst_n        receiver-domain clock, async active-low reset
//   enable            playout allowed while high
//   frame_req         one-cycle request for one sample
//   fifo_empty        FIFO empty flag, sampled at request acceptance
//   fifo_count        FIFO occupancy (unsigned)
//   fifo_dout         FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en        FIFO read strobe (cycle t+1)
//   sample_out        FIFO byte placed at bit SHIFT, other bits zero
//   sample_valid      one-cycle strobe (cycle t+3)
//   sample_silent     presented sample is silence
//   channel           0 = left, 1 = right
//   state             00 IDLE, 01 PREFILL, 10 PLAY
//   underrun_count    silent answers given in PLAY, saturating
//   req_overrun       sticky, a request arrived while one was in flight
// -----------------------------------------------------------------------------
module playout_scheduler #(
   parameter int DIN_W          = 8,
   parameter int DOUT_W         = 20,
   parameter int SHIFT          = 6,
   parameter int COUNT_W        = 10,
   parameter int PREFILL_LEVEL  = 512,
   parameter int UNDERRUN_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               frame_req,
   input  logic               fifo_empty,
   input  logic [COUNT_W-1:0] fifo_count,
   input  logic [DIN_W-1:0]   fifo_dout,
   output logic               fifo_rd_en,
   output logic [DOUT_W-1:0]  sample_out,
   output logic               sample_valid,
   output logic               sample_silent,
   output logic               channel,
   output logic [1:0]         state,
   output logic [7:0]         underrun_count,
   output logic               req_overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PREFILL = 2'b01,
      ST_PLAY    = 2'b10
   } state_t;

   localparam logic [COUNT_W-1:0] PREFILL_C = COUNT_W'(PREFILL_LEVEL);
   localparam logic [7:0]         LIMIT_C   = 8'(UNDERRUN_LIMIT);

   state_t              state_r;
   state_t              next_state_s;
   logic                busy_s;
   logic                accept_s;
   logic                play_s;
   logic                read_s;
   logic                underrun_s;
   logic                p1_r;
   logic                p2_r;
   logic                p2_rd_r;
   logic                fifo_rd_en_r;
   logic [DOUT_W-1:0]   sample_out_r;
   logic                sample_valid_r;
   logic                sample_silent_r;
   logic                channel_r;
   logic [7:0]          underrun_count_r;
   logic [7:0]          consec_r;
   logic                req_overrun_r;

   // Request acceptance, data-source decision and next-state logic.
   always_comb begin
      // In-flight window covers t+1..t+3, i.e. both pipe stages and the strobe.
      busy_s       = p1_r | p2_r | sample_valid_r;
      accept_s     = frame_req & ~busy_s;
      // A request coinciding with enable falling is answered with silence.
      play_s       = (state_r == ST_PLAY) & enable;
      read_s       = accept_s & play_s & ~fifo_empty;
      underrun_s   = accept_s & play_s & fifo_empty;
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) next_state_s = ST_PREFILL;
            else        next_state_s = ST_IDLE;
         end
         ST_PREFILL: begin
            if (!enable)                       next_state_s = ST_IDLE;
            else if (fifo_count >= PREFILL_C)  next_state_s = ST_PLAY;
            else                               next_state_s = ST_PREFILL;
         end
         ST_PLAY: begin
            if (!enable)                                           next_state_s = ST_IDLE;
            else if (underrun_s && ((consec_r + 8'd1) >= LIMIT_C)) next_state_s = ST_PREFILL;
            else                                                   next_state_s = ST_PLAY;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= next_state_s;
   end

   // Response pipeline: read strobe at t+1, data capture at t+2, strobe at t+3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_r            <= 1'b0;
         p2_r            <= 1'b0;
         p2_rd_r         <= 1'b0;
         fifo_rd_en_r    <= 1'b0;
         sample_valid_r  <= 1'b0;
         sample_silent_r <= 1'b0;
         sample_out_r    <= {DOUT_W{1'b0}};
      end else begin
         p1_r           <= accept_s;
         fifo_rd_en_r   <= read_s;
         p2_r           <= p1_r;
         p2_rd_r        <= fifo_rd_en_r;
         sample_valid_r <= p2_r;
         if (p2_r) begin
            sample_out_r    <= p2_rd_r ? (DOUT_W'(fifo_dout) << SHIFT) : {DOUT_W{1'b0}};
            sample_silent_r <= ~p2_rd_r;
         end else begin
            sample_out_r    <= sample_out_r;
            sample_silent_r <= sample_silent_r;
         end
      end
   end

   // Underrun bookkeeping: saturating total and consecutive-empty counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_count_r <= 8'd0;
         consec_r         <= 8'd0;
      end else begin
         if (underrun_s && (underrun_count_r != 8'hFF))
            underrun_count_r <= underrun_count_r + 8'd1;
         else
            underrun_count_r <= underrun_count_r;
         if (state_r != ST_PLAY)                 consec_r <= 8'd0;
         else if (read_s)                        consec_r <= 8'd0;
         else if (underrun_s && (next_state_s == ST_PREFILL)) consec_r <= 8'd0;
         else if (underrun_s)                    consec_r <= consec_r + 8'd1;
         else                                    consec_r <= consec_r;
      end
   end

   // Channel alternation (reset to left on PLAY entry) and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         channel_r     <= 1'b0;
         req_overrun_r <= 1'b0;
      end else begin
         if ((state_r != ST_PLAY) && (next_state_s == ST_PLAY)) channel_r <= 1'b0;
         else if (sample_valid_r)                                channel_r <= ~channel_r;
         else                                                    channel_r <= channel_r;
         req_overrun_r <= req_overrun_r | (frame_req & busy_s);
      end
   end

   assign fifo_rd_en     = fifo_rd_en_r;
   assign sample_out     = sample_out_r;
   assign sample_valid   = sample_valid_r;
   assign sample_silent  = sample_silent_r;
   assign channel        = channel_r;
   assign state          = state_r;
   assign underrun_count = underrun_count_r;
   assign req_overrun    = req_overrun_r;

endmodule

// File: tb/tb_playout_scheduler.sv
module tb_playout_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        frame_req;
   logic        fifo_empty;
   logic [9:0]  fifo_count;
   logic [7:0]  fifo_dout;
   logic        fifo_rd_en;
   logic [19:0] sample_out;
   logic        sample_valid;
   logic        sample_silent;
   logic        channel;
   logic [1:0]  state;
   logic [7:0]  underrun_count;
   logic        req_overrun;

   int checks;
   int failures;

   // bench FIFO contents, delivered one cycle after each read strobe
   logic [7:0] fifo_mem [0:7];
   logic [2:0] rd_ptr;

   // per-request captures
   logic        cap_rd1, cap_rd2, cap_v2, cap_v3, cap_silent, cap_ch;
   logic [1:0]  cap_state1, cap_state3;
   logic [19:0] cap_out;

   playout_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .frame_req      (frame_req),
      .fifo_empty     (fifo_empty),
      .fifo_count     (fifo_count),
      .fifo_dout      (fifo_dout),
      .fifo_rd_en     (fifo_rd_en),
      .sample_out     (sample_out),
      .sample_valid   (sample_valid),
      .sample_silent  (sample_silent),
      .channel        (channel),
      .state          (state),
      .underrun_count (underrun_count),
      .req_overrun    (req_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial rd_ptr = 3'd0;
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 3'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one request in a fresh cycle t and capture t+1..t+3 observations
   task automatic do_req(input logic drop_en);
      tick();
      frame_req = 1'b1;
      if (drop_en) enable = 1'b0;
      tick();
      frame_req  = 1'b0;
      cap_rd1    = fifo_rd_en;
      cap_state1 = state;
      tick();
      cap_rd2 = fifo_rd_en;
      cap_v2  = sample_valid;
      tick();
      cap_v3     = sample_valid;
      cap_out    = sample_out;
      cap_silent = sample_silent;
      cap_ch     = channel;
      cap_state3 = state;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; frame_req = 1'b0;
      fifo_empty = 1'b1; fifo_count = 10'd0;
      #12;
      checks++;
      if ({fifo_rd_en, sample_valid, sample_silent, channel, req_overrun} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_flags: got %b want 00000",
                  {fifo_rd_en, sample_valid, sample_silent, channel, req_overrun});
      end
      checks++;
      if (state !== 2'b00 || sample_out !== 20'h0 || underrun_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_values: state=%b out=%h uc=%0d want 00/00000/0", state, sample_out, underrun_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_prefill();
      enable = 1'b1; fifo_count = 10'd100; fifo_empty = 1'b0;
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0);
         checks++;
         if (cap_v2 !== 1'b0 || cap_v3 !== 1'b1 || cap_silent !== 1'b1 || cap_out !== 20'h0) begin
            failures++;
            $display("FAIL prefill_silent[%0d]: v2=%b v3=%b sil=%b out=%h want 0/1/1/00000", i, cap_v2, cap_v3, cap_silent, cap_out);
         end
         checks++;
         if (cap_rd1 !== 1'b0 || cap_rd2 !== 1'b0) begin
            failures++;
            $display("FAIL prefill_no_read[%0d]: rd=%b%b want 00", i, cap_rd1, cap_rd2);
         end
         checks++;
         if (cap_ch !== ((i % 2 == 1) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL prefill_channel[%0d]: got %b want %0d", i, cap_ch, i % 2);
         end
      end
      checks++;
      if (state !== 2'b01) begin
         failures++;
         $display("FAIL prefill_state: got %b want 01", state);
      end
   endtask

   task automatic test_play();
      logic [19:0] exp_out [0:1];
      exp_out[0] = 20'h02940;
      exp_out[1] = 20'h00F00;
      fifo_count = 10'd512;
      tick(); tick();
      checks++;
      if (state !== 2'b10) begin
         failures++;
         $display("FAIL play_entry: got %b want 10", state);
      end
      for (int i = 0; i < 2; i++) begin
         do_req(1'b0);
         checks++;
         if (cap_rd1 !== 1'b1 || cap_rd2 !== 1'b0) begin
            failures++;
            $display("FAIL play_read[%0d]: rd t+1/t+2=%b%b want 10", i, cap_rd1, cap_rd2);
         end
         checks++;
         if (cap_v2 !== 1'b0 || cap_v3 !== 1'b1 || cap_silent !== 1'b0) begin
            failures++;
            $display("FAIL play_strobe[%0d]: v2=%b v3=%b sil=%b want 0/1/0", i, cap_v2, cap_v3, cap_silent);
         end
         checks++;
         if (cap_out !== exp_out[i] || cap_ch !== ((i == 1) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL play_data[%0d]: out=%h ch=%b want %h ch=%0d", i, cap_out, cap_ch, exp_out[i], i);
         end
      end
   endtask

   task automatic test_underrun();
      fifo_count = 10'd100; fifo_empty = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0);
         checks++;
         if (cap_v3 !== 1'b1 || cap_silent !== 1'b1 || cap_out !== 20'h0 || cap_rd1 !== 1'b0) begin
            failures++;
            $display("FAIL underrun_silent[%0d]: v3=%b sil=%b out=%h rd=%b want 1/1/00000/0", i, cap_v3, cap_silent, cap_out, cap_rd1);
         end
         if (i < 3) begin
            checks++;
            if (cap_state3 !== 2'b10) begin
               failures++;
               $display("FAIL underrun_stay_play[%0d]: got %b want 10", i, cap_state3);
            end
         end else begin
            checks++;
            if (cap_state1 !== 2'b01 || state !== 2'b01) begin
               failures++;
               $display("FAIL underrun_reprefill: t+1=%b now=%b want 01", cap_state1, state);
            end
         end
      end
      checks++;
      if (underrun_count !== 8'd4) begin
         failures++;
         $display("FAIL underrun_count: got %0d want 4", underrun_count);
      end
   endtask

   task automatic test_back_to_back();
      int vcount;
      int rcount;
      fifo_empty = 1'b0; fifo_count = 10'd512;
      tick(); tick();
      checks++;
      if (state !== 2'b10 || req_overrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_pre: state=%b ovr=%b want 10/0", state, req_overrun);
      end
      vcount = 0; rcount = 0;
      tick(); frame_req = 1'b1;
      tick(); frame_req = 1'b0;
      vcount += int'(sample_valid); rcount += int'(fifo_rd_en);
      tick(); frame_req = 1'b1;
      vcount += int'(sample_valid); rcount += int'(fifo_rd_en);
      tick(); frame_req = 1'b0;
      vcount += int'(sample_valid); rcount += int'(fifo_rd_en);
      for (int i = 0; i < 6; i++) begin
         tick();
         vcount += int'(sample_valid); rcount += int'(fifo_rd_en);
      end
      checks++;
      if (vcount != 1 || rcount != 1) begin
         failures++;
         $display("FAIL b2b_single: valids=%0d reads=%0d want 1/1", vcount, rcount);
      end
      checks++;
      if (req_overrun !== 1'b1) begin
         failures++;
         $display("FAIL b2b_overrun: got %b want 1", req_overrun);
      end
      do_req(1'b0);
      checks++;
      if (req_overrun !== 1'b1) begin
         failures++;
         $display("FAIL b2b_sticky: got %b want 1", req_overrun);
      end
   endtask

   task automatic test_enable_drop();
      fifo_empty = 1'b0;
      do_req(1'b1);
      checks++;
      if (cap_state1 !== 2'b00) begin
         failures++;
         $display("FAIL drop_state: got %b want 00", cap_state1);
      end
      checks++;
      if (cap_rd1 !== 1'b0 || cap_rd2 !== 1'b0) begin
         failures++;
         $display("FAIL drop_no_read: rd=%b%b want 00", cap_rd1, cap_rd2);
      end
      checks++;
      if (cap_v3 !== 1'b1 || cap_silent !== 1'b1 || cap_out !== 20'h0) begin
         failures++;
         $display("FAIL drop_silent: v3=%b sil=%b out=%h want 1/1/00000", cap_v3, cap_silent, cap_out);
      end
   endtask

   task automatic test_reset_mid();
      int vcount;
      enable = 1'b1; fifo_count = 10'd512; fifo_empty = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (state !== 2'b10) begin
         failures++;
         $display("FAIL rstmid_play: got %b want 10", state);
      end
      tick(); frame_req = 1'b1;
      tick(); frame_req = 1'b0;
      checks++;
      if (fifo_rd_en !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_read: got %b want 1", fifo_rd_en);
      end
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({fifo_rd_en, sample_valid, sample_silent, channel, req_overrun} !== 5'b00000 ||
          state !== 2'b00 || sample_out !== 20'h0 || underrun_count !== 8'd0) begin
         failures++;
         $display("FAIL rstmid_clear: flags=%b state=%b out=%h uc=%0d want 00000/00/00000/0",
                  {fifo_rd_en, sample_valid, sample_silent, channel, req_overrun}, state, sample_out, underrun_count);
      end
      #2 rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vcount += int'(sample_valid);
      end
      checks++;
      if (vcount != 0) begin
         failures++;
         $display("FAIL rstmid_no_valid: got %0d strobes want 0", vcount);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      fifo_mem[0] = 8'hA5; fifo_mem[1] = 8'h3C; fifo_mem[2] = 8'h11; fifo_mem[3] = 8'h22;
      fifo_mem[4] = 8'h33; fifo_mem[5] = 8'h44; fifo_mem[6] = 8'h55; fifo_mem[7] = 8'h66;
      test_reset();
      test_prefill();
      test_play();
      test_underrun();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
